// File: rtl/llsc_mem_ctrl_if.sv
// MEM-stage ll/sc bus: the pipeline's MEM-stage controls and operands for
// one instruction, and the sc decision plus LLbit write going back out.
// Handshake: there is no ready. An instruction is consumed on a rising edge
// exactly when valid_i=1, stall=0 and flush=0. sc decisions are
// combinational in the same cycle. LLbit_we_o/LLbit_value_o are registered
// and describe the write the LLbit register performs on the following edge.
interface llsc_mem_ctrl_if;
    logic        flush;
    logic        stall;
    logic        valid_i;
    logic        is_ll_i;
    logic        is_sc_i;
    logic        is_store_i;
    logic [31:0] mem_addr_i;
    logic        LLbit_i;
    logic        mem_we_o;
    logic        sc_result_o;
    logic        LLbit_we_o;
    logic        LLbit_value_o;
    logic        link_valid_o;
    logic [31:0] link_addr_o;

    // Pipeline side: drives the instruction, observes the decision.
    modport master (
        output flush, stall, valid_i, is_ll_i, is_sc_i, is_store_i,
               mem_addr_i, LLbit_i,
        input  mem_we_o, sc_result_o, LLbit_we_o, LLbit_value_o,
               link_valid_o, link_addr_o
    );

    // Controller side.
    modport slave (
        input  flush, stall, valid_i, is_ll_i, is_sc_i, is_store_i,
               mem_addr_i, LLbit_i,
        output mem_we_o, sc_result_o, LLbit_we_o, LLbit_value_o,
               link_valid_o, link_addr_o
    );
endinterface

// File: rtl/llsc_mem_ctrl.sv
// MEM-stage ll/sc controller. Tracks the linked word, decides sc success
// combinationally, and issues the registered LLbit write consumed at WB.
// Its own in-flight LLbit write is forwarded so back-to-back ll/sc works.
// Optional macro LLSC_TIMEOUT_EN: a live link is force-cleared after
// TIMEOUT_CYCLES unstalled cycles without an ll/sc/matching-store event.
// The FSM state is visible as link_valid_o (1 = LINKED).
module llsc_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic           clk,
    input  logic           rst,
    llsc_mem_ctrl_if.slave bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        LINKED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] link_addr_q, link_addr_d;
    logic        llbit_we_q, llbit_we_d;
    logic        llbit_val_q, llbit_val_d;

    logic act;
    logic aligned;
    logic addr_hit;
    logic eff_llbit;
    logic sc_ok;

    // Counter must be able to represent TIMEOUT_CYCLES-1.
    if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cnt_w_check
        $error("CNT_W too small for TIMEOUT_CYCLES");
    end

    assign act       = bus.valid_i & ~bus.stall & ~bus.flush;
    assign aligned   = (bus.mem_addr_i[1:0] == 2'b00);
    assign addr_hit  = (bus.mem_addr_i[31:2] == link_addr_q);
    // A write still on its way to the LLbit register overrides its value.
    assign eff_llbit = llbit_we_q ? llbit_val_q : bus.LLbit_i;
    assign sc_ok     = bus.valid_i & bus.is_sc_i & eff_llbit & (state_q == LINKED)
                     & addr_hit & aligned & ~bus.flush;

`ifdef LLSC_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             link_event;

    assign link_event = act & ((bus.is_ll_i & aligned) | bus.is_sc_i
                             | (bus.is_store_i & (state_q == LINKED) & addr_hit));

    // Link-age counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // State register plus registered LLbit write and linked word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            link_addr_q <= '0;
            llbit_we_q  <= 1'b0;
            llbit_val_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            link_addr_q <= link_addr_d;
            llbit_we_q  <= llbit_we_d;
            llbit_val_q <= llbit_val_d;
        end
    end

    // Next-state: flush beats stall beats ll/sc/store decode.
    always_comb begin
        state_d     = state_q;
        link_addr_d = link_addr_q;
        llbit_we_d  = 1'b0;
        llbit_val_d = llbit_val_q;
`ifdef LLSC_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        if (bus.flush) begin
            state_d     = IDLE;
            llbit_val_d = 1'b0;
`ifdef LLSC_TIMEOUT_EN
            cnt_d       = '0;
`endif
        end else if (!bus.stall) begin
`ifdef LLSC_TIMEOUT_EN
            if (state_q == LINKED) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST && !link_event) begin
                    state_d     = IDLE;
                    llbit_we_d  = 1'b1;
                    llbit_val_d = 1'b0;
                    cnt_d       = '0;
                end
            end
`endif
            if (act && bus.is_ll_i) begin
                // Misaligned ll leaves everything alone; the exception is raised elsewhere.
                if (aligned) begin
                    state_d     = LINKED;
                    link_addr_d = bus.mem_addr_i[31:2];
                    llbit_we_d  = 1'b1;
                    llbit_val_d = 1'b1;
`ifdef LLSC_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end else if (act && bus.is_sc_i) begin
                // Any sc, successful or not, consumes the link.
                state_d     = IDLE;
                llbit_we_d  = 1'b1;
                llbit_val_d = 1'b0;
            end else if (act && bus.is_store_i && state_q == LINKED && addr_hit) begin
                state_d     = IDLE;
                llbit_we_d  = 1'b1;
                llbit_val_d = 1'b0;
            end
        end
    end

    // Outputs: combinational sc decision and registered LLbit write.
    always_comb begin
        bus.mem_we_o      = sc_ok;
        bus.sc_result_o   = sc_ok;
        bus.LLbit_we_o    = llbit_we_q;
        bus.LLbit_value_o = llbit_val_q;
        bus.link_valid_o  = (state_q == LINKED);
        bus.link_addr_o   = {link_addr_q, 2'b00};
    end

endmodule

// File: tb/tb_llsc_mem_ctrl.sv
// Bench for llsc_mem_ctrl with a small LLbit register model at WB.
// Build with or without LLSC_TIMEOUT_EN; TIMEOUT_CYCLES is set to 8.
module tb_llsc_mem_ctrl;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic llbit_q;

    logic [1:0] exp_comb_q[$];
    logic [2:0] exp_reg_q[$];

    llsc_mem_ctrl_if bus();

    llsc_mem_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef LLSC_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LLbit register at WB: clears on flush, otherwise takes the write.
    always @(posedge clk or posedge rst) begin
        if (rst)                 llbit_q <= 1'b0;
        else if (bus.flush)      llbit_q <= 1'b0;
        else if (bus.LLbit_we_o) llbit_q <= bus.LLbit_value_o;
    end
    assign bus.LLbit_i = llbit_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.valid_i    = 1'b0;
        bus.is_ll_i    = 1'b0;
        bus.is_sc_i    = 1'b0;
        bus.is_store_i = 1'b0;
        bus.mem_addr_i = 32'h0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
    endtask

    // Entered at posedge+1. Drives one cycle, checks the combinational
    // result at the falling edge and the registered result after the edge.
    task automatic step(input string tag, input bit v, input bit ll, input bit sc,
                        input bit st, input logic [31:0] addr, input bit stl, input bit fl,
                        input bit e_mwe, input bit e_scr,
                        input bit e_we, input bit e_val, input bit e_link);
        logic [1:0] c;
        logic [2:0] r;
        bus.valid_i    = v;
        bus.is_ll_i    = ll;
        bus.is_sc_i    = sc;
        bus.is_store_i = st;
        bus.mem_addr_i = addr;
        bus.stall      = stl;
        bus.flush      = fl;
        exp_comb_q.push_back({e_mwe, e_scr});
        exp_reg_q.push_back({e_we, e_val, e_link});
        @(negedge clk);
        c = exp_comb_q.pop_front();
        check_eq({tag, ".mem_we"},    32'(bus.mem_we_o),    32'(c[1]));
        check_eq({tag, ".sc_result"}, 32'(bus.sc_result_o), 32'(c[0]));
        @(posedge clk);
        #1;
        r = exp_reg_q.pop_front();
        check_eq({tag, ".llbit_we"},  32'(bus.LLbit_we_o),    32'(r[2]));
        check_eq({tag, ".llbit_val"}, 32'(bus.LLbit_value_o), 32'(r[1]));
        check_eq({tag, ".link_vld"},  32'(bus.link_valid_o),  32'(r[0]));
        drive_idle();
    endtask

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive_idle();
        #12;
        check_eq("rst.llbit_we",  32'(bus.LLbit_we_o),    32'h0);
        check_eq("rst.llbit_val", 32'(bus.LLbit_value_o), 32'h0);
        check_eq("rst.link_vld",  32'(bus.link_valid_o),  32'h0);
        check_eq("rst.link_addr", bus.link_addr_o,        32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ll then sc to the same word, relying on the forwarded LLbit.
        step("t1.ll",     1,1,0,0, 32'h1000, 0,0,  0,0, 1,1,1);
        check_eq("t1.link_addr", bus.link_addr_o, 32'h1000);
        step("t1.sc",     1,0,1,0, 32'h1000, 0,0,  1,1, 1,0,0);
        step("t1.ll_mis", 1,1,0,0, 32'h1001, 0,0,  0,0, 0,0,0);

        // Matching store breaks the link; store to another word does not.
        step("t2.ll",     1,1,0,0, 32'h1000, 0,0,  0,0, 1,1,1);
        step("t2.sw",     1,0,0,1, 32'h1000, 0,0,  0,0, 1,0,0);
        step("t2.sc",     1,0,1,0, 32'h1000, 0,0,  0,0, 1,0,0);
        step("t2b.ll",    1,1,0,0, 32'h1000, 0,0,  0,0, 1,1,1);
        step("t2b.sw",    1,0,0,1, 32'h1004, 0,0,  0,0, 0,1,1);
        step("t2b.sc",    1,0,1,0, 32'h1000, 0,0,  1,1, 1,0,0);

        // Wrong word, misaligned sc, re-link to a new address.
        step("t3.ll",     1,1,0,0, 32'h1000, 0,0,  0,0, 1,1,1);
        step("t3.sc_oth", 1,0,1,0, 32'h2000, 0,0,  0,0, 1,0,0);
        check_eq("t3.link_after", 32'(bus.link_valid_o), 32'h0);
        step("t3b.ll",    1,1,0,0, 32'h1000, 0,0,  0,0, 1,1,1);
        step("t3b.sc_mis",1,0,1,0, 32'h1002, 0,0,  0,0, 1,0,0);
        step("t3c.ll",    1,1,0,0, 32'h1000, 0,0,  0,0, 1,1,1);
        step("t3c.relink",1,1,0,0, 32'h3000, 0,0,  0,0, 1,1,1);
        check_eq("t3c.link_addr", bus.link_addr_o, 32'h3000);
        step("t3c.sc",    1,0,1,0, 32'h3000, 0,0,  1,1, 1,0,0);

        // Flush kills the link and the LLbit register.
        step("t4.ll",     1,1,0,0, 32'h1000, 0,0,  0,0, 1,1,1);
        step("t4.flush",  0,0,0,0, 32'h0000, 0,1,  0,0, 0,0,0);
        step("t4.sc",     1,0,1,0, 32'h1000, 0,0,  0,0, 1,0,0);

        // Asynchronous reset between ll and sc.
        step("t5.ll",     1,1,0,0, 32'h1000, 0,0,  0,0, 1,1,1);
        #1 rst = 1'b1;
        #1;
        check_eq("t5.rst_we",   32'(bus.LLbit_we_o),    32'h0);
        check_eq("t5.rst_val",  32'(bus.LLbit_value_o), 32'h0);
        check_eq("t5.rst_link", 32'(bus.link_valid_o),  32'h0);
        check_eq("t5.rst_addr", bus.link_addr_o,        32'h0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        step("t5.sc",     1,0,1,0, 32'h1000, 0,0,  0,0, 1,0,0);

        // Stalled ll forms no link until released.
        for (int i = 0; i < 3; i++)
            step("t6.ll_stall", 1,1,0,0, 32'h1000, 1,0,  0,0, 0,0,0);
        step("t6.ll",     1,1,0,0, 32'h1000, 0,0,  0,0, 1,1,1);

        // Eight idle cycles: the link times out only with the feature built in.
        for (int i = 0; i < 8; i++) begin
            bit to;
            to = TIMEOUT_ON && (i == 7);
            step("t7.idle", 0,0,0,0, 32'h0, 0,0,  0,0, to, !to, !to);
        end
        step("t7.sc",     1,0,1,0, 32'h1000, 0,0,  !TIMEOUT_ON, !TIMEOUT_ON, 1,0,0);

        check_eq("sb.comb_empty", 32'(exp_comb_q.size()), 32'h0);
        check_eq("sb.reg_empty",  32'(exp_reg_q.size()),  32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/llsc_mem_ctrl.md
Name: llsc_mem_ctrl

Overview:
- MEM-stage controller for ll/sc atomics, directly upstream of the LLbit register.
- Tracks the linked word address and decides sc success, gating the sc store and producing its rt result (1/0).
- Drives the registered LLbit write (we/value) consumed by the LLbit register at WB.
- Forwards its own pending LLbit write so back-to-back ll/sc sees the correct link state.

Parameters:
TIMEOUT_CYCLES, 1024, cycles a link may stay live before forced clear (used only with LLSC_TIMEOUT_EN)
CNT_W, 11, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high (rst==1 resets immediately, independent of clk)
flush  input  1  exception flush; 1 = squash
stall  input  1  MEM stage stalled; 1 = hold
valid_i  input  1  MEM-stage instruction valid
is_ll_i  input  1  instruction is ll
is_sc_i  input  1  instruction is sc
is_store_i  input  1  instruction is a plain store (sb/sh/sw/swl/swr), not sc
mem_addr_i  input  32  effective address
LLbit_i  input  1  current LLbit register value
mem_we_o  output  1  store enable for sc (combinational); plain stores are not gated here
sc_result_o  output  1  value written to rt by sc (combinational)
LLbit_we_o  output  1  registered LLbit write enable to LLbit register
LLbit_value_o  output  1  registered LLbit write value
link_valid_o  output  1  1 while state==LINKED
link_addr_o  output  32  {link_addr_q, 2'b00}

Behaviour:
- Reset: state IDLE, link_addr_q=0, LLbit_we_o=0, LLbit_value_o=0, counter=0. link_valid_o=0, link_addr_o=0.
- States:
  - IDLE: no link.
  - LINKED: link_addr_q[29:0]=mem_addr_i[31:2] captured by ll.
- Effective LLbit: eff = LLbit_we_o ? LLbit_value_o : LLbit_i. This forwards a write still in flight to the LLbit register.
- Active event: act = valid_i & ~stall & ~flush.
- ll, act & is_ll_i & mem_addr_i[1:0]==0:
  - next LLbit_we_o=1, LLbit_value_o=1.
  - link_addr_q<=mem_addr_i[31:2]; state LINKED; counter<=0.
  - ll while already LINKED re-links to the new address.
- Misaligned ll: no state change; LLbit_we_o<=0. Exception is raised elsewhere.
- sc, combinational:
  - ok = valid_i & is_sc_i & eff & state==LINKED & mem_addr_i[31:2]==link_addr_q & mem_addr_i[1:0]==0 & ~flush.
  - mem_we_o=ok; sc_result_o=ok. Both are 0 for non-sc instructions.
- sc, registered when act & is_sc_i (success or fail): LLbit_we_o<=1, LLbit_value_o<=0, state IDLE.
- Plain store, act & is_store_i & state==LINKED & mem_addr_i[31:2]==link_addr_q:
  - LLbit_we_o<=1, LLbit_value_o<=0, state IDLE.
  - A store to a different word has no effect.
- Any other act cycle: LLbit_we_o<=0.
- stall=1 and flush=0: state, link_addr_q and counter held. LLbit_we_o<=0 (bubble toward WB); LLbit_value_o held.
- flush=1, highest priority after rst: state IDLE, LLbit_we_o<=0, LLbit_value_o<=0. The LLbit register clears itself on flush.
- Priority: rst > flush > stall > ll/sc/store decode.
- Latency: sc decision is combinational in the same cycle. The LLbit update reaches LLbit_we_o/LLbit_value_o one clock later.
- Async reset mid-operation (e.g. between ll and sc): immediate return to reset values; a following sc fails.

Optional Feature:
LLSC_TIMEOUT_EN
- Defined:
  - Counter increments each clock while LINKED and not stalled.
  - When it reaches TIMEOUT_CYCLES-1 with no ll/sc/store event that cycle: state IDLE, LLbit_we_o<=1, LLbit_value_o<=0, counter<=0.
  - A same-cycle ll takes priority and restarts the count.
- Undefined: no counter is instantiated; links persist until sc, matching store, flush or reset. Parameters remain but are ignored.

Test Plan:
- ll @0x0000_1000, next cycle sc @0x0000_1000 (forwarding path) -> mem_we_o=1, sc_result_o=1. LLbit_we_o=1/LLbit_value_o=1 after ll, then 1/0 after sc.
- ll @0x1000, sw @0x1000, sc @0x1000 -> sc_result_o=0, mem_we_o=0. Repeat with sw @0x1004 -> sc_result_o=1.
- ll @0x1000 then sc @0x2000 -> sc_result_o=0, state IDLE, LLbit_value_o=0. Misaligned sc @0x1002 after ll @0x1000 -> fail.
- ll @0x1000, flush pulse, sc @0x1000 with LLbit_i=0 -> sc_result_o=0. Assert rst mid-cycle after ll -> outputs zero without a clock edge.
- ll with stall=1 for 3 cycles -> no link formed, LLbit_we_o=0 throughout. Release stall -> link forms, LLbit_we_o=1 next cycle.
- LLSC_TIMEOUT_EN, TIMEOUT_CYCLES=8: ll then wait 8 cycles -> LLbit_we_o=1/LLbit_value_o=0, link_valid_o=0; subsequent sc fails. Without macro, same sc succeeds.
